lane_accel_host_master: RTL
===========================

Name: lane_accel_host_master

Overview:
- Initiator-side driver for the lane-detection accelerator's memory-mapped slave port.
- Accepts a pixel stream and, on request, issues a soft reset. Writes every pixel into the input region, then polls the output-valid register.
- Reads back the output map as 32-bit words onto a result stream, then fetches the accelerator clock counter.
- Sits between a host/DMA pixel source and the accelerator top.

Parameters:
- AXI_ADDR_WIDTH, 20, width of wr/rd address ports.
- NUM_PIXELS, 131072, pixels per frame (512x256).
- OUT_WORDS, 512, 32-bit words in the output map (64x32 bytes / 4).
- OFFSET_OUTPUT, 393216, byte address of output map.
- OFFSET_OVALID, 395264, output-valid register address.
- OFFSET_RESET, 395272, soft-reset register address.
- OFFSET_CLOCK_CNT, 589824, clock-counter register address.
- TIMEOUT_CYCLES, 16777216, poll cycles before timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse: begin a frame (ignored unless IDLE)
- do_soft_reset  in  1  sampled with start: issue soft reset first
- s_pix_data  in  24  {B,G,R}, 8 bits each
- s_pix_valid  in  1  pixel valid
- s_pix_ready  out  1  pixel accepted when valid&ready
- m_res_data  out  32  output-map word
- m_res_valid  out  1  result valid
- m_res_ready  in  1  result consumer ready
- m_res_last  out  1  high on word OUT_WORDS-1
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse at frame completion
- timeout_err  out  1  sticky until next start
- clock_cnt  out  32  accelerator cycle count captured at end of frame
- axi_wr_data  out  32  write data
- axi_wr_addr  out  AXI_ADDR_WIDTH  write byte address
- axi_wr_en  out  1  write strobe
- axi_wr_strobe  out  4  byte enables
- axi_rd_addr  out  AXI_ADDR_WIDTH  read byte address
- axi_rd_en  out  1  read enable
- axi_rd_data  in  32  read data

Behaviour:
- Reset:
  - FSM enters IDLE.
  - All outputs 0: s_pix_ready, m_res_valid, m_res_last, busy, done, timeout_err, clock_cnt, all axi_* outputs.
- Write and read outputs are registered.
- Slave write semantics: a write takes effect in the cycle axi_wr_en=1.
- Slave read semantics:
  - Register reads (OVALID, CLOCK_CNT) are combinational on axi_rd_addr.
  - Output-map reads need axi_rd_en=1 at address A in cycle N, with axi_rd_addr still A in cycle N+1. Data is sampled at the end of N+1.
- States: IDLE, SRST, SRST_WAIT, LOAD, POLL, RD_ISSUE, RD_CAPTURE, RD_HOLD, CNT, DONE.
- IDLE:
  - On start, clear timeout_err and the pixel/word counters.
  - Go to SRST if do_soft_reset=1, else LOAD.
- SRST:
  - Single write: addr=OFFSET_RESET, data=1, strobe=4'b0001.
  - Then go to SRST_WAIT.
- SRST_WAIT: wait 16 cycles (covers the slave's 15-cycle internal reset), then LOAD.
- LOAD:
  - s_pix_ready=1.
  - Each accepted pixel i produces next cycle a write with addr=3*i, data={8'h00,s_pix_data}, strobe=4'b0111. Pixel i=0 is the frame-start trigger.
  - Max one pixel per cycle, no bubbles required.
  - After pixel NUM_PIXELS-1 is accepted, drop s_pix_ready the following cycle and go to POLL.
- POLL:
  - axi_rd_addr=OFFSET_OVALID, axi_rd_en=0.
  - If axi_rd_data[0]=1, go to RD_ISSUE.
  - A 24-bit poll counter runs; on reaching TIMEOUT_CYCLES-1, set timeout_err=1 and go to DONE (no readback).
- RD_ISSUE:
  - axi_rd_addr=OFFSET_OUTPUT+4*w, axi_rd_en=1, then RD_CAPTURE.
- RD_CAPTURE:
  - Hold the address, axi_rd_en=0.
  - Load axi_rd_data into the m_res_data register; assert m_res_valid, with m_res_last=(w==OUT_WORDS-1).
  - Go to RD_HOLD.
- RD_HOLD:
  - Wait for m_res_ready.
  - On the handshake, drop m_res_valid (or not, if re-issued), w++, and go to RD_ISSUE, or to CNT if w was last.
  - m_res_data must remain stable while m_res_valid=1 and m_res_ready=0.
- CNT: axi_rd_addr=OFFSET_CLOCK_CNT; capture axi_rd_data into clock_cnt next cycle, then DONE.
- DONE: pulse done for one cycle, then IDLE.
- Boundaries:
  - start while busy is ignored.
  - s_pix_valid outside LOAD is never accepted.
  - The word counter wraps only via start.
  - Async reset mid-frame aborts immediately with no further writes. The slave frame is left partial; the next frame must use do_soft_reset=1.

Test Plan:
- NUM_PIXELS=8, OUT_WORDS=4, do_soft_reset=0, slave model asserts ovalid 20 cycles after the last write:
  - Expect 8 writes at addrs 0,3,...,21 with strobe 0111.
  - Expect 4 result words matching model memory, m_res_last only on word 3, then done with clock_cnt equal to the model value.
- do_soft_reset=1:
  - First write is addr 395272, data 1, strobe 0001.
  - The pixel-0 write occurs no earlier than 17 cycles later.
- Random m_res_ready backpressure (30% high): all 4 words delivered in order, and m_res_data is stable during every stall.
- Slave never asserts ovalid, TIMEOUT_CYCLES=64: timeout_err=1 after 64 poll cycles, done pulses, zero result beats.
- start asserted during LOAD, and s_pix_valid held high in IDLE: no extra writes and no pixel accepted outside LOAD.
- rst_n dropped after pixel 3: all outputs return to 0 asynchronously. A new start with do_soft_reset=1 then completes a clean frame.

Source files
------------

// File: rtl/lane_accel_host_master.sv
// Host-side master: streams a frame of pixels into the lane accelerator, polls for completion, reads back the output map and cycle count.
// Latency: one cycle from pixel accept to its write; each result word takes issue + capture + hold (>= 3 cycles).
// Backpressure: s_pix_ready is high only while loading; result reads stall in RD_HOLD until m_res_ready.
module lane_accel_host_master #(
    parameter int          AXI_ADDR_WIDTH   = 20,
    parameter int unsigned NUM_PIXELS       = 131072,
    parameter int unsigned OUT_WORDS        = 512,
    parameter int unsigned OFFSET_OUTPUT    = 393216,
    parameter int unsigned OFFSET_OVALID    = 395264,
    parameter int unsigned OFFSET_RESET     = 395272,
    parameter int unsigned OFFSET_CLOCK_CNT = 589824,
    parameter int unsigned TIMEOUT_CYCLES   = 16777216
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      do_soft_reset,
    input  logic [23:0]               s_pix_data,
    input  logic                      s_pix_valid,
    output logic                      s_pix_ready,
    output logic [31:0]               m_res_data,
    output logic                      m_res_valid,
    input  logic                      m_res_ready,
    output logic                      m_res_last,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout_err,
    output logic [31:0]               clock_cnt,
    output logic [31:0]               axi_wr_data,
    output logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
    output logic                      axi_wr_en,
    output logic [3:0]                axi_wr_strobe,
    output logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr,
    output logic                      axi_rd_en,
    input  logic [31:0]               axi_rd_data
);

    localparam int PW = $clog2(NUM_PIXELS + 1);
    localparam int WW = $clog2(OUT_WORDS + 1);

    localparam logic [PW-1:0]             PIX_LAST     = PW'(NUM_PIXELS - 1);
    localparam logic [WW-1:0]             WORD_LAST    = WW'(OUT_WORDS - 1);
    localparam logic [23:0]               POLL_LAST    = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_OUTPUT  = AXI_ADDR_WIDTH'(OFFSET_OUTPUT);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_OVALID  = AXI_ADDR_WIDTH'(OFFSET_OVALID);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_RESET   = AXI_ADDR_WIDTH'(OFFSET_RESET);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_CLOCK   = AXI_ADDR_WIDTH'(OFFSET_CLOCK_CNT);

    typedef enum logic [3:0] {
        IDLE, SRST, SRST_WAIT, LOAD, POLL, RD_ISSUE, RD_CAPTURE, RD_HOLD, CNT, DONE
    } state_t;

    state_t                    state;
    logic [PW-1:0]             pix_cnt;
    logic [AXI_ADDR_WIDTH-1:0] pix_addr;
    logic [WW-1:0]             word_cnt;
    logic [23:0]               poll_cnt;
    logic [3:0]                srst_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pix_cnt       <= '0;
            pix_addr      <= '0;
            word_cnt      <= '0;
            poll_cnt      <= '0;
            srst_cnt      <= '0;
            s_pix_ready   <= 1'b0;
            m_res_data    <= '0;
            m_res_valid   <= 1'b0;
            m_res_last    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout_err   <= 1'b0;
            clock_cnt     <= '0;
            axi_wr_data   <= '0;
            axi_wr_addr   <= '0;
            axi_wr_en     <= 1'b0;
            axi_wr_strobe <= '0;
            axi_rd_addr   <= '0;
            axi_rd_en     <= 1'b0;
        end else begin
            // Strobes and the done pulse last exactly one cycle unless re-asserted below.
            axi_wr_en <= 1'b0;
            axi_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        pix_cnt     <= '0;
                        pix_addr    <= '0;
                        word_cnt    <= '0;
                        if (do_soft_reset) begin
                            state         <= SRST;
                            axi_wr_en     <= 1'b1;
                            axi_wr_addr   <= ADDR_RESET;
                            axi_wr_data   <= 32'd1;
                            axi_wr_strobe <= 4'b0001;
                        end else begin
                            state       <= LOAD;
                            s_pix_ready <= 1'b1;
                        end
                    end
                end
                SRST: begin
                    srst_cnt <= '0;
                    state    <= SRST_WAIT;
                end
                SRST_WAIT: begin
                    // 16 idle cycles outlast the slave's internal 15-cycle reset.
                    srst_cnt <= srst_cnt + 4'd1;
                    if (srst_cnt == 4'd15) begin
                        state       <= LOAD;
                        s_pix_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (s_pix_valid && s_pix_ready) begin
                        axi_wr_en     <= 1'b1;
                        axi_wr_addr   <= pix_addr;
                        axi_wr_data   <= {8'h00, s_pix_data};
                        axi_wr_strobe <= 4'b0111;
                        pix_addr      <= pix_addr + AXI_ADDR_WIDTH'(3);
                        pix_cnt       <= pix_cnt + PW'(1);
                        if (pix_cnt == PIX_LAST) begin
                            s_pix_ready <= 1'b0;
                            state       <= POLL;
                            axi_rd_addr <= ADDR_OVALID;
                            poll_cnt    <= '0;
                        end
                    end
                end
                POLL: begin
                    if (axi_rd_data[0]) begin
                        state       <= RD_ISSUE;
                        axi_rd_addr <= ADDR_OUTPUT;
                        axi_rd_en   <= 1'b1;
                    end else if (poll_cnt == POLL_LAST) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        poll_cnt <= poll_cnt + 24'd1;
                    end
                end
                RD_ISSUE: state <= RD_CAPTURE;
                RD_CAPTURE: begin
                    // Address is still held from the issue cycle, so the map data is valid now.
                    m_res_data  <= axi_rd_data;
                    m_res_valid <= 1'b1;
                    m_res_last  <= (word_cnt == WORD_LAST);
                    state       <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (m_res_ready) begin
                        m_res_valid <= 1'b0;
                        m_res_last  <= 1'b0;
                        if (word_cnt == WORD_LAST) begin
                            state       <= CNT;
                            axi_rd_addr <= ADDR_CLOCK;
                        end else begin
                            word_cnt    <= word_cnt + WW'(1);
                            axi_rd_addr <= axi_rd_addr + AXI_ADDR_WIDTH'(4);
                            axi_rd_en   <= 1'b1;
                            state       <= RD_ISSUE;
                        end
                    end
                end
                CNT: begin
                    clock_cnt <= axi_rd_data;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
